seq_addsub: RTL and testbench

- Parametrised, multi-cycle two's-complement adder/subtractor; generalises the team's 4-bit ripple-carry add/sub to WIDTH bits.
- Processes CHUNK bits per clock and ripples the carry through a register between cycles, which keeps the carry chain short for long operands.
- Valid/ready handshake on both input and output, so it drops directly into datapath pipelines.

---
 rtl/seq_addsub.sv | 135 +++++++++++++
 tb/tb_seq_addsub.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_addsub.sv
// rtl/seq_addsub.sv - multi-cycle chunked two's-complement adder/subtractor with valid/ready handshake
// Optional signed saturation on overflow when SEQ_ADDSUB_SAT_EN is defined.
module seq_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int MSB    = WIDTH - 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [IDXW-1:0]  idx_q, idx_d;

    logic             accept;
    logic             last_chunk;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_res;
    logic             ovf_now;

    assign accept     = in_valid && (state_q == S_IDLE);
    assign last_chunk = (idx_q == LAST_IDX);
    assign a_chunk    = a_q[idx_q*CHUNK +: CHUNK];
    assign b_chunk    = b_q[idx_q*CHUNK +: CHUNK];
    assign chunk_res  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};

    // b_q already holds the effective (possibly inverted) operand, so its MSB is B'[MSB].
    assign ovf_now    = (a_q[MSB] == b_q[MSB]) && (chunk_res[CHUNK-1] != a_q[MSB]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)     state_d = S_RUN;
            S_RUN:   if (last_chunk) state_d = S_DONE;
            S_DONE:  if (out_ready)  state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;
        if (accept) begin
            a_d     = a;
            b_d     = b ^ {WIDTH{sub}};
            carry_d = sub;
            idx_d   = '0;
        end else if (state_q == S_RUN) begin
            sum_d[idx_q*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
            carry_d = chunk_res[CHUNK];
            idx_d   = idx_q + 1'b1;
            if (last_chunk) begin
                idx_d  = '0;
                cout_d = chunk_res[CHUNK];
                ovf_d  = ovf_now;
`ifdef SEQ_ADDSUB_SAT_EN
                if (ovf_now) begin
                    sum_d = a_q[MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_addsub.sv
// tb/tb_seq_addsub.sv - directed table-driven bench for seq_addsub (WIDTH=16, CHUNK=4)
module tb_seq_addsub;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vsub;
        logic [15:0] esum;
        logic        ecout;
        logic        eovf;
    } vec_t;

    vec_t vecs[9];

    seq_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one operation from a negedge in IDLE; returns results and edges from accept to out_valid.
    task automatic run_op(input logic [15:0] oa, input logic [15:0] ob, input logic osub,
                          output logic [15:0] rsum, output logic rcout, output logic rovf,
                          output int lat);
        int wait_n;
        wait_n = 0;
        while (!in_ready && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        a        = oa;
        b        = ob;
        sub      = osub;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a        = 16'hDEAD;
        b        = 16'hBEEF;
        sub      = ~osub;
        lat      = 0;
        while (!out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        rsum  = sum;
        rcout = cout;
        rovf  = ovf;
    endtask

    initial begin
        logic [15:0] rs;
        logic        rc;
        logic        ro;
        int          lat;
        logic [15:0] held;

        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
`ifdef SEQ_ADDSUB_SAT_EN
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
`else
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
`endif
        vecs[2] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
`ifdef SEQ_ADDSUB_SAT_EN
        vecs[3] = '{16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b1};
`else
        vecs[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
`endif
        vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[8] = '{16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_in_ready",  32'(in_ready),  32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_sum",       32'(sum),       32'd0);
        chk("reset_cout",      32'(cout),      32'd0);
        chk("reset_ovf",       32'(ovf),       32'd0);

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vsub, rs, rc, ro, lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
            chk($sformatf("vec%0d_sum", i),     32'(rs),  32'(vecs[i].esum));
            chk($sformatf("vec%0d_cout", i),    32'(rc),  32'(vecs[i].ecout));
            chk($sformatf("vec%0d_ovf", i),     32'(ro),  32'(vecs[i].eovf));
            @(negedge clk);
            chk($sformatf("vec%0d_release_valid", i), 32'(out_valid), 32'd0);
            chk($sformatf("vec%0d_release_ready", i), 32'(in_ready),  32'd1);
        end

        // Backpressure: result held for 6 cycles while new operands are waved at the input.
        out_ready = 1'b0;
        run_op(16'h1234, 16'h0FFF, 1'b0, rs, rc, ro, lat);
        chk("bp_latency", 32'(lat), 32'd4);
        held = sum;
        in_valid = 1'b1;
        a        = 16'h4444;
        b        = 16'h4444;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("bp_hold%0d_ready", k), 32'(in_ready),  32'd0);
            chk($sformatf("bp_hold%0d_sum", k),   32'({cout, ovf, sum}), 32'({1'b0, 1'b0, 16'h2233}));
        end
        chk("bp_sum_unchanged", 32'(held), 32'h2233);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready),  32'd1);
        chk("bp_release_sum",   32'(sum),       32'h2233);

        // Reset two edges after accept aborts the operation.
        a        = 16'hFFFF;
        b        = 16'hFFFF;
        sub      = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready",  32'(in_ready),  32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_sum",       32'(sum),       32'd0);
        chk("abort_flags",     32'({cout, ovf}), 32'd0);
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_result", 32'(out_valid), 32'd0);
        end
        run_op(16'h00FF, 16'h0001, 1'b0, rs, rc, ro, lat);
        chk("post_abort_latency", 32'(lat), 32'd4);
        chk("post_abort_sum",     32'(rs),  32'h0100);
        @(negedge clk);

        // Back-to-back stream with in_valid held high and out_ready tied high.
        begin
            logic [15:0] sa[3];
            logic [15:0] sb[3];
            logic        ss[3];
            logic [15:0] se[3];
            int          acc_cyc[3];
            int          acc_n;
            int          res_n;
            int          cyc;
            sa = '{16'h1111, 16'h0005, 16'hFFFF};
            sb = '{16'h2222, 16'h0007, 16'h0001};
            ss = '{1'b0,     1'b1,     1'b0};
            se = '{16'h3333, 16'hFFFE, 16'h0000};
            acc_n = 0;
            res_n = 0;
            cyc   = 0;
            a        = sa[0];
            b        = sb[0];
            sub      = ss[0];
            in_valid = 1'b1;
            while (res_n < 3 && cyc < 60) begin
                if (out_valid) begin
                    chk($sformatf("stream_res%0d", res_n), 32'(sum), 32'(se[res_n]));
                    res_n++;
                end
                if (in_ready && in_valid) begin
                    acc_cyc[acc_n] = cyc;
                    acc_n++;
                end
                @(negedge clk);
                cyc++;
                if (acc_n >= 3) begin
                    in_valid = 1'b0;
                end else begin
                    a   = sa[acc_n];
                    b   = sb[acc_n];
                    sub = ss[acc_n];
                end
            end
            chk("stream_results", 32'(res_n), 32'd3);
            chk("stream_accepts", 32'(acc_n), 32'd3);
            if (acc_n == 3) begin
                chk("stream_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
                chk("stream_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
